// File: rtl/block_aligner_pkg.sv
// Shared PCS constants, types and sync-header helper used across the RX path.
// Common to the lock FSM, the block aligner and the decoder.
package block_aligner_pkg;
  localparam int NB_CODED_BLOCK  = 66;
  localparam int NB_INDEX        = $clog2(NB_CODED_BLOCK);
  localparam int MAX_INDEX_VALUE = NB_CODED_BLOCK - 2;
  localparam int NB_WINDOW       = 2 * NB_CODED_BLOCK;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef logic [NB_CODED_BLOCK-1:0] block_t;
  typedef logic [NB_INDEX-1:0]       index_t;

  typedef enum logic {
    BUF_EMPTY,
    BUF_PRIMED
  } buf_state_t;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction
endpackage

// File: rtl/block_aligner_if.sv
// Handshake and data bundle between the lock FSM / gearbox side and the block aligner.
// master drives the i_* inputs; slave is the aligner.
interface block_aligner_if #(parameter int NB_BAD_SH_CNT = 16);
  import block_aligner_pkg::*;

  logic                     i_enable;
  logic                     i_valid;
  logic                     i_signal_ok;
  block_t                   i_data;
  index_t                   i_search_index;
  index_t                   i_block_index;
  logic                     i_block_lock;
  logic                     i_clear_count;
  logic                     o_sh_valid;
  block_t                   o_data;
  logic                     o_valid;
  logic                     o_block_lock;
  logic                     o_slip;
  logic [NB_BAD_SH_CNT-1:0] o_bad_sh_count;

  modport master (
    output i_enable, i_valid, i_signal_ok, i_data, i_search_index,
           i_block_index, i_block_lock, i_clear_count,
    input  o_sh_valid, o_data, o_valid, o_block_lock, o_slip, o_bad_sh_count
  );

  modport slave (
    input  i_enable, i_valid, i_signal_ok, i_data, i_search_index,
           i_block_index, i_block_lock, i_clear_count,
    output o_sh_valid, o_data, o_valid, o_block_lock, o_slip, o_bad_sh_count
  );
endinterface

// File: rtl/block_window_slicer.sv
// Cuts a 66-bit block out of a 132-bit two-word window at a given offset.
// Purely combinational; header valid is forced low for offsets past the last legal one.
module block_window_slicer
  import block_aligner_pkg::*;
(
  input  logic [NB_WINDOW-1:0] window,
  input  index_t               index,
  output block_t               slice,
  output logic                 sh_valid
);

  logic idx_legal;

  // Offset k selects window[131-k -: 66]: shift left by k, keep the top word.
  assign slice     = block_t'((window << index) >> NB_CODED_BLOCK);
  assign idx_legal = (index <= index_t'(MAX_INDEX_VALUE));
  assign sh_valid  = idx_legal && sh_is_valid(slice[NB_CODED_BLOCK-1 -: 2]);

endmodule

// File: rtl/block_aligner.sv
// RX block aligner: two-word window, zero-latency header probe for the lock FSM, aligned block out.
// Block output latency 1 accepted word; no backpressure, words advance only when i_enable && i_valid.
module block_aligner
  import block_aligner_pkg::*;
#(
  parameter int NB_BAD_SH_CNT = 16
) (
  input logic            i_clock,
  input logic            i_reset,
  block_aligner_if.slave bus
);

  buf_state_t               state_q, state_d;
  block_t                   prev_q, prev_d;
  index_t                   last_q, last_d;
  block_t                   data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     slip_q, slip_d;
  logic                     lock_q, lock_d;
  logic [NB_BAD_SH_CNT-1:0] cnt_q, cnt_d;

  logic [NB_WINDOW-1:0] window;
  block_t               search_slice_unused;
  logic                 search_sh_vld;
  block_t               blk_slice;
  logic                 blk_sh_vld;
  logic                 blk_legal;
  logic                 accept;
  logic                 bad_hdr;

  assign window = {prev_q, bus.i_data};

  block_window_slicer u_search_slicer (
    .window   (window),
    .index    (bus.i_search_index),
    .slice    (search_slice_unused),
    .sh_valid (search_sh_vld)
  );

  block_window_slicer u_block_slicer (
    .window   (window),
    .index    (bus.i_block_index),
    .slice    (blk_slice),
    .sh_valid (blk_sh_vld)
  );

  assign accept    = bus.i_enable && bus.i_valid;
  assign blk_legal = (bus.i_block_index <= index_t'(MAX_INDEX_VALUE));
  // Flush outranks accept, so a word arriving during a flush is never counted.
  assign bad_hdr   = accept && bus.i_signal_ok && (state_q == BUF_PRIMED) &&
                     bus.i_block_lock && !blk_sh_vld;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    last_d  = last_q;
    data_d  = data_q;
    valid_d = 1'b0;
    slip_d  = 1'b0;
    lock_d  = lock_q;
    cnt_d   = cnt_q;

    if (!bus.i_signal_ok) begin
      state_d = BUF_EMPTY;
      last_d  = '0;
      lock_d  = 1'b0;
    end else if (accept) begin
      state_d = BUF_PRIMED;
      prev_d  = bus.i_data;
      lock_d  = bus.i_block_lock;
      if (state_q == BUF_PRIMED) begin
        last_d = bus.i_block_index;
        // A changed offset means this word straddles two alignments: drop it.
        if (blk_legal) begin
          if (bus.i_block_index == last_q) begin
            data_d  = blk_slice;
            valid_d = 1'b1;
          end else begin
            slip_d = 1'b1;
          end
        end
      end
    end

    if (bus.i_clear_count) begin
      cnt_d = '0;
    end else if (bad_hdr && !(&cnt_q)) begin
      cnt_d = cnt_q + NB_BAD_SH_CNT'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= BUF_EMPTY;
      prev_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      slip_q  <= 1'b0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      slip_q  <= slip_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_sh_valid     = (state_q == BUF_PRIMED) && search_sh_vld;
  assign bus.o_data         = data_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_slip         = slip_q;
  assign bus.o_block_lock   = lock_q;
  assign bus.o_bad_sh_count = cnt_q;

endmodule

// File: tb/tb_block_aligner.sv
// Randomized bench for block_aligner with a word-level reference model.
// Counter width reduced to 2 so saturation is reachable in a few words.
module tb_block_aligner;
  import block_aligner_pkg::*;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  block_aligner_if #(.NB_BAD_SH_CNT(CNT_W)) bus ();

  block_aligner #(.NB_BAD_SH_CNT(CNT_W)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_primed;
  logic [65:0] m_prev;
  int          m_last;
  int          m_cnt;
  logic [65:0] e_data;
  bit          e_valid, e_slip, e_lock, e_sh;
  logic        act_sh;

  function automatic logic [65:0] ref_slice(input logic [65:0] prev, input logic [65:0] cur, input int k);
    logic [131:0] w;
    logic [65:0]  s;
    w = {prev, cur};
    s = '0;
    if (k <= 64) begin
      for (int i = 0; i < 66; i++) s[65-i] = w[131-k-i];
    end
    return s;
  endfunction

  function automatic bit ref_hdr_good(input int k, input logic [65:0] prev, input logic [65:0] cur);
    logic [65:0] s;
    if (k > 64) return 1'b0;
    s = ref_slice(prev, cur, k);
    return s[65] ^ s[64];
  endfunction

  function automatic logic [65:0] rnd66();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[65:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [71:0] pack_got();
    return {act_sh, bus.o_valid, bus.o_slip, bus.o_block_lock, bus.o_bad_sh_count, bus.o_data};
  endfunction

  function automatic logic [71:0] pack_exp();
    return {e_sh, e_valid, e_slip, e_lock, CNT_W'(m_cnt), e_data};
  endfunction

  task automatic model_reset();
    m_primed = 1'b0; m_prev = '0; m_last = 0; m_cnt = 0;
    e_data = '0; e_valid = 1'b0; e_slip = 1'b0; e_lock = 1'b0; e_sh = 1'b0;
  endtask

  // Drive one cycle, capture the combinational header flag, clock, advance the model.
  task automatic apply(input bit en, input bit vld, input bit ok, input logic [65:0] d,
                       input int sidx, input int bidx, input bit lock, input bit clr);
    bit          acc;
    logic [65:0] s;
    bus.i_enable       = en;
    bus.i_valid        = vld;
    bus.i_signal_ok    = ok;
    bus.i_data         = d;
    bus.i_search_index = index_t'(sidx);
    bus.i_block_index  = index_t'(bidx);
    bus.i_block_lock   = lock;
    bus.i_clear_count  = clr;
    #1;
    e_sh   = m_primed && ref_hdr_good(sidx, m_prev, d);
    act_sh = bus.o_sh_valid;
    @(posedge clk);
    acc = en && vld;
    s   = ref_slice(m_prev, d, bidx);
    if (clr) m_cnt = 0;
    else if (ok && acc && m_primed && lock && !ref_hdr_good(bidx, m_prev, d) && m_cnt < CNT_MAX)
      m_cnt = m_cnt + 1;
    e_valid = 1'b0;
    e_slip  = 1'b0;
    if (!ok) begin
      m_primed = 1'b0; m_last = 0; e_lock = 1'b0;
    end else if (acc) begin
      e_lock = lock;
      if (m_primed) begin
        if (bidx <= 64) begin
          if (bidx == m_last) begin e_data = s; e_valid = 1'b1; end
          else e_slip = 1'b1;
        end
        m_last = bidx;
      end
      m_prev   = d;
      m_primed = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_enable = 0; bus.i_valid = 0; bus.i_signal_ok = 1; bus.i_data = '0;
    bus.i_search_index = '0; bus.i_block_index = '0; bus.i_block_lock = 0; bus.i_clear_count = 0;
    #2 rst = 1'b1;
    #2;
    act_sh = bus.o_sh_valid;
    model_reset();
    vectors++;
    if (pack_got() !== 72'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", pack_got(), 72'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_aligned();
    logic [65:0] w [8];
    apply(0, 0, 0, '0, 0, 0, 0, 1);
    for (int j = 0; j < 8; j++) begin
      w[j] = {SH_DATA, rnd64()};
      apply(1, 1, 1, w[j], 0, 0, 1, 0);
      vectors++;
      if (pack_got() !== pack_exp()) begin
        miscompares++;
        $display("FAIL aligned_model word %0d: got %h want %h", j, pack_got(), pack_exp());
      end
      vectors++;
      if (j >= 1 && (bus.o_valid !== 1'b1 || bus.o_data !== w[j-1] || act_sh !== 1'b1)) begin
        miscompares++;
        $display("FAIL aligned_data word %0d: valid %b data %h sh %b want 1 %h 1", j, bus.o_valid, bus.o_data, act_sh, w[j-1]);
      end else if (j == 0 && (bus.o_valid !== 1'b0 || act_sh !== 1'b0)) begin
        miscompares++;
        $display("FAIL aligned_first: valid %b sh %b want 0 0", bus.o_valid, act_sh);
      end
    end
    vectors++;
    if (bus.o_bad_sh_count !== 2'd0) begin
      miscompares++;
      $display("FAIL aligned_count: got %0d want 0", bus.o_bad_sh_count);
    end
  endtask

  task automatic test_offset13();
    logic [65:0] b [10];
    logic [65:0] w [10];
    logic [12:0] lead;
    for (int j = 0; j < 10; j++) b[j] = {($urandom_range(0, 1) == 1) ? SH_CTRL : SH_DATA, rnd64()};
    lead = 13'($urandom);
    w[0] = {lead, b[0][65:13]};
    for (int j = 1; j < 10; j++) w[j] = {b[j-1][12:0], b[j][65:13]};
    apply(0, 0, 0, '0, 0, 0, 0, 1);
    for (int j = 0; j < 10; j++) begin
      apply(1, 1, 1, w[j], 13, 13, 1, 0);
      vectors++;
      if (pack_got() !== pack_exp()) begin
        miscompares++;
        $display("FAIL offset13_model word %0d: got %h want %h", j, pack_got(), pack_exp());
      end
      if (j >= 1) begin
        vectors++;
        if (act_sh !== 1'b1) begin
          miscompares++;
          $display("FAIL offset13_sh word %0d: got %b want 1", j, act_sh);
        end
      end
      if (j >= 2) begin
        vectors++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== b[j-1]) begin
          miscompares++;
          $display("FAIL offset13_block word %0d: valid %b data %h want 1 %h", j, bus.o_valid, bus.o_data, b[j-1]);
        end
      end
    end
  endtask

  task automatic test_slip();
    apply(0, 0, 0, '0, 0, 0, 0, 1);
    for (int j = 0; j < 10; j++) begin
      apply(1, 1, 1, rnd66(), 5, (j < 6) ? 5 : 6, 0, 0);
      vectors++;
      if (pack_got() !== pack_exp()) begin
        miscompares++;
        $display("FAIL slip_model word %0d: got %h want %h", j, pack_got(), pack_exp());
      end
      if (j == 6) begin
        vectors++;
        if (bus.o_slip !== 1'b1 || bus.o_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL slip_pulse: slip %b valid %b want 1 0", bus.o_slip, bus.o_valid);
        end
      end else if (j == 7) begin
        vectors++;
        if (bus.o_slip !== 1'b0 || bus.o_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL slip_recover: slip %b valid %b want 0 1", bus.o_slip, bus.o_valid);
        end
      end
    end
  endtask

  task automatic test_illegal_index();
    apply(0, 0, 0, '0, 0, 0, 0, 1);
    apply(1, 1, 1, rnd66(), 65, 65, 1, 0);
    for (int j = 0; j < 3; j++) begin
      apply(1, 1, 1, {SH_DATA, rnd64()}, 65, 65, 1, 0);
      vectors++;
      if (act_sh !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_bad_sh_count !== CNT_W'(j + 1)) begin
        miscompares++;
        $display("FAIL illegal65 word %0d: sh %b valid %b cnt %0d want 0 0 %0d", j, act_sh, bus.o_valid, bus.o_bad_sh_count, j + 1);
      end
    end
  endtask

  task automatic test_saturate_clear();
    apply(0, 0, 0, '0, 0, 0, 0, 1);
    for (int j = 0; j < 5; j++) begin
      apply(1, 1, 1, {(j % 2 == 0) ? 2'b00 : 2'b11, rnd64()}, 0, 0, 1, 0);
      vectors++;
      if (pack_got() !== pack_exp()) begin
        miscompares++;
        $display("FAIL saturate_model word %0d: got %h want %h", j, pack_got(), pack_exp());
      end
    end
    vectors++;
    if (bus.o_bad_sh_count !== 2'd3) begin
      miscompares++;
      $display("FAIL saturate_count: got %0d want 3", bus.o_bad_sh_count);
    end
    apply(1, 1, 1, {2'b00, rnd64()}, 0, 0, 1, 1);
    vectors++;
    if (bus.o_bad_sh_count !== 2'd0) begin
      miscompares++;
      $display("FAIL clear_priority: got %0d want 0", bus.o_bad_sh_count);
    end
  endtask

  task automatic test_flush_reset();
    logic [65:0] a;
    apply(0, 0, 0, '0, 0, 0, 0, 1);
    apply(1, 1, 1, {2'b11, rnd64()}, 0, 0, 1, 0);
    apply(1, 1, 1, {2'b00, rnd64()}, 0, 0, 1, 0);
    apply(1, 1, 1, {SH_DATA, rnd64()}, 0, 0, 1, 0);
    apply(1, 1, 1, {SH_DATA, rnd64()}, 0, 0, 1, 0);
    apply(1, 1, 0, {SH_DATA, rnd64()}, 0, 0, 1, 0);
    vectors++;
    if (bus.o_valid !== 1'b0 || bus.o_block_lock !== 1'b0 || bus.o_bad_sh_count !== 2'd2) begin
      miscompares++;
      $display("FAIL flush_state: valid %b lock %b cnt %0d want 0 0 2", bus.o_valid, bus.o_block_lock, bus.o_bad_sh_count);
    end
    apply(1, 1, 1, {SH_DATA, rnd64()}, 0, 0, 1, 0);
    vectors++;
    if (act_sh !== 1'b0 || bus.o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_empty: sh %b valid %b want 0 0", act_sh, bus.o_valid);
    end
    apply(1, 1, 1, {SH_DATA, rnd64()}, 0, 0, 1, 0);
    vectors++;
    if (bus.o_valid !== 1'b1 || act_sh !== 1'b1 || bus.o_bad_sh_count !== 2'd2) begin
      miscompares++;
      $display("FAIL flush_resume: valid %b sh %b cnt %0d want 1 1 2", bus.o_valid, act_sh, bus.o_bad_sh_count);
    end
    #2 rst = 1'b1;
    #1;
    act_sh = bus.o_sh_valid;
    vectors++;
    if (pack_got() !== 72'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", pack_got(), 72'h0);
    end
    #1 rst = 1'b0;
    model_reset();
    a = {SH_CTRL, rnd64()};
    apply(1, 1, 1, a, 0, 0, 1, 0);
    vectors++;
    if (bus.o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_word: valid %b want 0", bus.o_valid);
    end
    apply(1, 1, 1, {SH_DATA, rnd64()}, 0, 0, 1, 0);
    vectors++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== a) begin
      miscompares++;
      $display("FAIL reset_second_word: valid %b data %h want 1 %h", bus.o_valid, bus.o_data, a);
    end
  endtask

  task automatic test_random();
    int base_s, base_b, sidx, bidx;
    int choices [5] = '{0, 13, 63, 64, 65};
    logic [65:0] d;
    base_s = 0;
    base_b = 0;
    for (int j = 0; j < 300; j++) begin
      if ($urandom_range(0, 15) == 0) base_b = choices[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0) base_s = choices[$urandom_range(0, 4)];
      sidx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : base_s;
      bidx = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 127) : base_b;
      d = rnd66();
      apply($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 19) != 0,
            d, sidx, bidx, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      vectors++;
      if (pack_got() !== pack_exp()) begin
        miscompares++;
        $display("FAIL random cycle %0d sidx %0d bidx %0d: got %h want %h", j, sidx, bidx, pack_got(), pack_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_offset13();
    test_slip();
    test_illegal_index();
    test_saturate_clear();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/block_aligner.md
Name: block_aligner

Overview:
Sits directly downstream of the sync-header lock FSM in the RX PCS. It receives raw, unaligned 66-bit words from the gearbox and keeps a two-word window. From that window it:
- extracts the 2-bit header at the FSM's search index and returns a zero-latency sh-valid flag that closes the lock loop;
- slices the aligned 66-bit block at the FSM's block index and sends it downstream (descrambler/decoder), with slip and bad-header monitoring.

Parameters:
NB_CODED_BLOCK, 66, width of a coded block and of the input word
NB_INDEX, $clog2(NB_CODED_BLOCK), width of block/search index
MAX_INDEX_VALUE, NB_CODED_BLOCK-2, highest legal index (64)
NB_BAD_SH_CNT, 16, width of the saturating bad-header counter

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_enable  in  1  global enable
i_valid  in  1  input word valid
i_signal_ok  in  1  PMA signal ok; low acts as a synchronous flush
i_data  in  NB_CODED_BLOCK  raw word; bit [NB_CODED_BLOCK-1] is first on the line
i_search_index  in  NB_INDEX  header probe offset from the lock FSM
i_block_index  in  NB_INDEX  locked block offset from the lock FSM
i_block_lock  in  1  lock flag from the lock FSM
i_clear_count  in  1  synchronous clear of the bad-header counter
o_sh_valid  out  1  header at search index is 01 or 10 (combinational)
o_data  out  NB_CODED_BLOCK  aligned block, header in the top 2 bits
o_valid  out  1  o_data valid, one-cycle pulse
o_block_lock  out  1  i_block_lock delayed to align with o_data
o_slip  out  1  pulse: block was dropped because the block index changed
o_bad_sh_count  out  NB_BAD_SH_CNT  invalid headers seen while locked (saturating)

Behaviour:
- Accept = i_enable && i_valid. Only accepted cycles change state, except reset and flush.
- Window = {prev_word, i_data}, 132 bits. The slice at index k is window[131-k -: 66]. The header at k is window[131-k -: 2].
- A legal index is 0..MAX_INDEX_VALUE. An index above that is illegal: the header is treated as invalid and no block is produced.
- Word-buffer FSM:
  - EMPTY (no prev_word) -> PRIMED on the first accepted word (prev_word <= i_data).
  - PRIMED: prev_word <= i_data on every accepted word.
  - Any state -> EMPTY on reset or i_signal_ok=0. Flush has priority over accept.
- o_sh_valid = PRIMED && legal(i_search_index) && header in {01,10}.
  - Purely combinational, zero latency, so the lock FSM sees it in the same cycle as i_valid.
  - It is 0 in EMPTY. The lock FSM therefore takes exactly one slip after reset or flush; this is intended.
- Data path, registered, latency 1 from the accepted word:
  - On accept in PRIMED with a legal i_block_index:
    - if i_block_index == last_index: o_data <= slice, o_valid <= 1, o_slip <= 0;
    - otherwise: o_valid <= 0, o_slip <= 1, o_data holds.
  - last_index <= i_block_index on every accept in PRIMED.
  - On accept in EMPTY, or with an illegal index: o_valid <= 0, o_slip <= 0.
  - On a cycle with no accept: o_valid <= 0, o_slip <= 0, o_data holds.
  - o_block_lock <= i_block_lock on every accept; otherwise it holds.
- Bad-header counter:
  - Increments on accept && PRIMED && i_block_lock && header at i_block_index not in {01,10} (an illegal index counts as bad).
  - Saturates at all ones.
  - Priority: reset, then i_clear_count, then increment. It is not cleared by a signal_ok flush.
- Reset (asynchronous) values: prev_word=0, state=EMPTY, last_index=0, o_data=0, o_valid=0, o_block_lock=0, o_slip=0, o_bad_sh_count=0.
- Flush (i_signal_ok=0, synchronous): state=EMPTY, last_index=0, o_valid=0, o_slip=0, o_block_lock=0. o_data and the counter hold.
- Reset mid-stream: the first block after reset appears on the cycle after the second accepted word.

Decomposition:
- Shared pcs package holds NB_CODED_BLOCK, NB_INDEX, MAX_INDEX_VALUE, SH_DATA=2'b01, SH_CTRL=2'b10, and a header-valid function. The same package is used by the lock FSM and the decoder.
- One combinational sub-module, block_window_slicer (132-bit window + index -> 66-bit slice + header-valid). It is instantiated twice: once at search index, once at block index.

Test Plan:
- Aligned stream: 66-bit words with header 01, both indices 0. Expected: after the second word, o_valid pulses every cycle, o_data equals the previous word, o_sh_valid=1, and the counter stays 0.
- 13-bit offset: stream shifted by 13 bits, both indices 13. Expected: o_data holds the original blocks with header 01/10, and o_sh_valid=1 every cycle.
- Slip: block index changes from 5 to 6 mid-stream. Expected: one cycle with o_slip=1 and o_valid=0, then the new alignment is valid the next cycle.
- Illegal index 65: expected o_sh_valid=0 and o_valid=0. With lock=1, o_bad_sh_count increments by 1 per word.
- Saturation and clear: NB_BAD_SH_CNT=2, lock=1, headers 00/11 for 5 words. Expected: the count sticks at 3. Asserting i_clear_count together with a bad header gives 0.
- Flush and reset: i_signal_ok=0 for 1 cycle mid-stream. Expected: EMPTY, o_sh_valid=0 on the next word, first o_valid one word later, counter retained. An asynchronous reset pulse between clock edges zeroes all outputs immediately.
